// File: rtl/denge_pkg.sv
// Shared types and constants for the rod-balance loop controller.
// Holds the FSM state encoding, the comparator code values and the settle timer width.
package denge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_ADD    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam logic [1:0] D_DENGE    = 2'b00;
    localparam logic [1:0] D_B_AGIR   = 2'b01;
    localparam logic [1:0] D_A_AGIR   = 2'b10;
    localparam logic [1:0] D_GECERSIZ = 2'b11;

    localparam int TMR_W = 4;

endpackage

// File: rtl/denge_ayarlayici_bekleme_sayaci.sv
// Loadable down-counter used as the settle timer after each add strobe.
// Stops at zero and reports it through the zero flag.
module bekleme_sayaci
    import denge_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Next timer value: load wins over decrement, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Timer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/denge_ayarlayici.sv
// Closed-loop rod balancer: samples the comparator code, strobes a weight onto
// the lighter side, waits for the rod to settle and repeats until balanced.
module denge_ayarlayici
    import denge_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       D,
    output logic             add_a,
    output logic             add_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // The timer counts remaining SETTLE cycles after the current one, so the
    // SETTLE state lasts exactly SETTLE cycles before returning to SAMPLE.
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE - 1);

    state_e           state_q, state_d;
    logic             add_a_q, add_a_d;
    logic             add_b_q, add_b_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tmr_load_s;
    logic             tmr_dec_s;
    logic             tmr_zero_s;

    bekleme_sayaci u_bekleme (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .dec      (tmr_dec_s),
        .load_val (SETTLE_LOAD),
        .zero     (tmr_zero_s)
    );

    // Next-state and registered-output computation for the balancing FSM.
    always_comb begin
        state_d    = state_q;
        add_a_d    = 1'b0;
        add_b_d    = 1'b0;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SAMPLE;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_SAMPLE: begin
                case (D)
                    D_DENGE: begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                    D_B_AGIR: begin
                        if (cnt_a_q == CNT_MAX) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_ERR;
                        end else begin
                            add_a_d = 1'b1;
                            cnt_a_d = cnt_a_q + CNT_ONE;
                            state_d = ST_ADD;
                        end
                    end
                    D_A_AGIR: begin
                        if (cnt_b_q == CNT_MAX) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_ERR;
                        end else begin
                            add_b_d = 1'b1;
                            cnt_b_d = cnt_b_q + CNT_ONE;
                            state_d = ST_ADD;
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_ERR;
                    end
                endcase
            end
            ST_ADD: begin
                tmr_load_s = 1'b1;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_zero_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            add_a_q <= 1'b0;
            add_b_q <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign add_a = add_a_q;
    assign add_b = add_b_q;
    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule
